// File: rtl/mux_n1_scan.sv
// mux_n1_scan: registered CHANNELS-to-1 multiplexer with manual select and a
// clocked auto-scan mode that dwells DWELL enabled cycles on each channel
// enabled in mask, then advances to the next enabled channel (with wrap).
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active-high
//   d        flattened inputs, channel k = d[k*WIDTH +: WIDTH]
//   sel      manual channel select
//   mode     0 = manual, 1 = scan
//   en       update enable; 0 freezes all state
//   mask     scan-mode channel enables (bit k = visit channel k)
//   y        registered selected data
//   ch       channel currently driven on y
//   y_valid  y holds data from a legal channel
//   wrap     one-cycle pulse when scan wraps to an equal or lower index
//   err      one-cycle pulse on an out-of-range manual select
module mux_n1_scan #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int DWELL    = 8,
  localparam int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      en,
  input  logic [CHANNELS-1:0]       mask,
  output logic [WIDTH-1:0]          y,
  output logic [SELW-1:0]           ch,
  output logic                      y_valid,
  output logic                      wrap,
  output logic                      err
);

  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  typedef enum logic {ST_MANUAL, ST_SCAN} state_t;

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_cnt,   w_cnt_nxt;
  logic [SELW-1:0]   r_ch,    w_ch_nxt;
  logic [WIDTH-1:0]  r_y,     w_y_nxt;
  logic              r_vld,   w_vld_nxt;
  logic              r_wrap,  w_wrap_nxt;
  logic              r_err,   w_err_nxt;
  logic [SELW-1:0]   w_entry;
  logic [SELW-1:0]   w_next;

  function automatic logic [WIDTH-1:0] pick(
    input logic [CHANNELS*WIDTH-1:0] din,
    input logic [SELW-1:0]           idx
  );
    logic [WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SELW'(k)) v = din[k*WIDTH +: WIDTH];
    end
    return v;
  endfunction

  // First set mask bit at or after 'from' (incl=1) or strictly after it
  // (incl=0), wrapping modulo CHANNELS. The strict search ends on 'from'
  // itself, so a lone set bit selects the same channel again.
  function automatic logic [SELW-1:0] next_set(
    input logic [CHANNELS-1:0] msk,
    input logic [SELW-1:0]     from,
    input logic                incl
  );
    logic [SELW-1:0] v;
    logic            found;
    int              idx;
    v     = from;
    found = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(from) + i + (incl ? 0 : 1);
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && msk[idx]) begin
        v     = SELW'(idx);
        found = 1'b1;
      end
    end
    return v;
  endfunction

  assign w_entry = next_set(mask, r_ch, 1'b1);
  assign w_next  = next_set(mask, r_ch, 1'b0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ch_nxt    = r_ch;
    w_y_nxt     = r_y;
    w_vld_nxt   = r_vld;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (en) begin
      if (!mode) begin
        // mode is checked first so a dwell boundary on the same edge is ignored
        w_state_nxt = ST_MANUAL;
        w_cnt_nxt   = '0;
        if (int'(sel) < CHANNELS) begin
          w_ch_nxt  = sel;
          w_y_nxt   = pick(d, sel);
          w_vld_nxt = 1'b1;
        end else begin
          w_vld_nxt = 1'b0;
          w_err_nxt = 1'b1;
        end
      end else begin
        w_state_nxt = ST_SCAN;
        if (mask == '0) begin
          w_vld_nxt = 1'b0;
          w_cnt_nxt = '0;
        end else if (r_state == ST_MANUAL) begin
          w_ch_nxt  = w_entry;
          w_y_nxt   = pick(d, w_entry);
          w_vld_nxt = 1'b1;
          w_cnt_nxt = '0;
        end else if (!r_vld || r_cnt == DWELL_LAST) begin
          // !r_vld in scan means the mask was empty: resume after ch, no wrap
          w_ch_nxt   = w_next;
          w_y_nxt    = pick(d, w_next);
          w_vld_nxt  = 1'b1;
          w_cnt_nxt  = '0;
          w_wrap_nxt = r_vld && (w_next <= r_ch);
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
          w_y_nxt   = pick(d, r_ch);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_MANUAL;
      r_cnt   <= '0;
      r_ch    <= '0;
      r_y     <= '0;
      r_vld   <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ch    <= w_ch_nxt;
      r_y     <= w_y_nxt;
      r_vld   <= w_vld_nxt;
      r_wrap  <= w_wrap_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign y       = r_y;
  assign ch      = r_ch;
  assign y_valid = r_vld;
  assign wrap    = r_wrap;
  assign err     = r_err;

endmodule
